// File: rtl/correlator_sequencer.sv
// correlator_sequencer: integrate / capture / flush controller for the correlator array.
// Captured frames sit in a shadow register that streams out one slot per beat.
module correlator_sequencer #(
    parameter int NUM_CORR     = 8,
    parameter int RESOLUTION   = 24,
    parameter int INTEG_WIDTH  = 32,
    parameter int CLEAR_CYCLES = 2,
    localparam int IDX_W       = (NUM_CORR > 1) ? $clog2(NUM_CORR) : 1,
    localparam int SLOT_W      = 2 * RESOLUTION
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_run,
    input  logic [INTEG_WIDTH-1:0]     i_integ_len,
    input  logic [NUM_CORR*SLOT_W-1:0] i_pulses,
    output logic                       o_corr_enable,
    output logic                       o_corr_reset,
    output logic [SLOT_W-1:0]          o_out_data,
    output logic [IDX_W-1:0]           o_out_index,
    output logic                       o_out_last,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [15:0]                o_frame_count,
    output logic                       o_overrun,
    input  logic                       i_overrun_clr,
    output logic                       o_busy,
    output logic [1:0]                 o_state
);

    // Handshake: a beat transfers on every clock where o_out_valid and i_out_ready
    // are both high. While valid is high and ready is low, data/index/last hold
    // steady, and valid only falls after the last slot of a frame has transferred.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_INTEG   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [INTEG_WIDTH-1:0] CLR_LOAD = INTEG_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_CORR - 1);

    state_t                 r_state;
    logic [INTEG_WIDTH-1:0] r_cnt;
    logic                   r_corr_enable;
    logic                   r_corr_reset;
    logic                   r_busy;

    logic [SLOT_W-1:0]      r_shadow [NUM_CORR];
    logic [SLOT_W-1:0]      r_out_data;
    logic [IDX_W-1:0]       r_out_index;
    logic                   r_out_last;
    logic                   r_out_valid;
    logic [15:0]            r_frame_count;
    logic                   r_overrun;

    logic [INTEG_WIDTH-1:0] w_len_m1;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_load;
    logic                   w_overrun_set;
    logic [IDX_W-1:0]       w_next_idx;

    // A zero length still integrates for one clock.
    assign w_len_m1      = (i_integ_len == '0) ? '0 : i_integ_len - INTEG_WIDTH'(1);
    assign w_accept      = r_out_valid && i_out_ready;
    assign w_capture     = (r_state == S_CAPTURE);
    // The shadow is free if empty, or if its last beat leaves on this very edge.
    assign w_load        = w_capture && (!r_out_valid || (w_accept && r_out_last));
    assign w_overrun_set = w_capture && !w_load;
    assign w_next_idx    = r_out_index + IDX_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_corr_enable <= 1'b0;
            r_corr_reset  <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= CLR_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - INTEG_WIDTH'(1);
                    end else if (i_run) begin
                        r_state       <= S_INTEG;
                        r_cnt         <= w_len_m1;
                        r_corr_enable <= 1'b1;
                        r_corr_reset  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_INTEG: begin
                    if (!i_run) begin
                        r_state       <= S_CLEAR;
                        r_cnt         <= CLR_LOAD;
                        r_corr_enable <= 1'b0;
                        r_corr_reset  <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state       <= S_CAPTURE;
                        r_corr_enable <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - INTEG_WIDTH'(1);
                    end
                end
                S_CAPTURE: begin
                    r_state      <= S_CLEAR;
                    r_cnt        <= CLR_LOAD;
                    r_corr_reset <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_corr_enable <= 1'b0;
                    r_corr_reset  <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CORR; i++) begin
                r_shadow[i] <= '0;
            end
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            for (int i = 0; i < NUM_CORR; i++) begin
                r_shadow[i] <= i_pulses[i*SLOT_W +: SLOT_W];
            end
            r_out_data  <= i_pulses[SLOT_W-1:0];
            r_out_index <= '0;
            r_out_last  <= (NUM_CORR == 1);
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            if (r_out_last) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_index <= '0;
            end else begin
                r_out_index <= w_next_idx;
                r_out_data  <= r_shadow[w_next_idx];
                r_out_last  <= (w_next_idx == LAST_IDX);
            end
        end
    end

    // A dropped frame still counts; a set of the sticky flag beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_corr_enable = r_corr_enable;
    assign o_corr_reset  = r_corr_reset;
    assign o_out_data    = r_out_data;
    assign o_out_index   = r_out_index;
    assign o_out_last    = r_out_last;
    assign o_out_valid   = r_out_valid;
    assign o_frame_count = r_frame_count;
    assign o_overrun     = r_overrun;
    assign o_busy        = r_busy;
    assign o_state       = r_state;

endmodule

// File: tb/tb_correlator_sequencer.sv
// Bench for correlator_sequencer: table of frame vectors, directed corner sequences,
// and a randomized run checked against a frame-level timeline model.
module tb_correlator_sequencer;
  localparam int NC = 4;
  localparam int R = 8;
  localparam int IW = 32;
  localparam int CC = 2;
  localparam int IDX_W = 2;
  localparam int SW = 2 * R;
  localparam int BW = 1 + IDX_W + SW;
  localparam int RND_CYCLES = 800;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic [IW-1:0] integ_len;
  logic [NC*SW-1:0] pulses;
  logic out_ready;
  logic overrun_clr;
  logic corr_enable;
  logic corr_reset;
  logic [SW-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic out_last;
  logic out_valid;
  logic [15:0] frame_count;
  logic overrun;
  logic busy;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int stub_mode = 0;
  int rise_q[$];
  logic prev_en = 1'b0;
  logic [BW-1:0] exp_q[$];

  typedef struct {
    int len;
    int exp_en;
    int exp_val;
    int exp_period;
  } vec_t;
  vec_t vecs[4];

  // model state
  logic m_running;
  int m_start;
  int m_cap;
  int m_len;
  logic m_en;
  logic m_rst;
  logic m_ovr;
  logic m_busy;
  logic [15:0] m_fc;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  correlator_sequencer #(
    .NUM_CORR(NC), .RESOLUTION(R), .INTEG_WIDTH(IW), .CLEAR_CYCLES(CC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_integ_len(integ_len),
    .i_pulses(pulses), .o_corr_enable(corr_enable), .o_corr_reset(corr_reset),
    .o_out_data(out_data), .o_out_index(out_index), .o_out_last(out_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_frame_count(frame_count),
    .o_overrun(overrun), .i_overrun_clr(overrun_clr), .o_busy(busy), .o_state(state_dbg)
  );

  // correlator stub: real += 1 per enabled edge; imag += 1 (mode 0) or slot+1 (mode 1)
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (corr_reset) begin
        pulses[i*SW +: SW] <= '0;
      end else if (corr_enable) begin
        pulses[i*SW +: R] <= pulses[i*SW +: R] + R'(1);
        pulses[i*SW+R +: R] <= pulses[i*SW+R +: R] + ((stub_mode == 1) ? R'(i + 1) : R'(1));
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (corr_enable && !prev_en) rise_q.push_back(cyc);
    prev_en <= corr_enable;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;
    integ_len = '0;
    stub_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (!corr_enable && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(corr_enable), 32'd1);
  endtask

  task automatic check_beat(input string name, input int k, input int re, input int im);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_index"}, 32'(out_index), 32'(k));
    chk({name, "_last"}, 32'(out_last), 32'(k == NC - 1));
    chk({name, "_real"}, 32'(out_data[R-1:0]), 32'(re));
    chk({name, "_imag"}, 32'(out_data[SW-1:R]), 32'(im));
  endtask

  // ---------------- reference model ----------------
  task automatic model_init();
    m_running = 1'b0;
    m_start = -10;
    m_cap = -10;
    m_len = 1;
    m_en = 1'b0;
    m_rst = 1'b1;
    m_ovr = 1'b0;
    m_busy = 1'b0;
    m_fc = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input int c);
    logic set_ovr;
    logic [BW-1:0] tmp;
    set_ovr = 1'b0;
    if (exp_q.size() > 0 && out_ready) tmp = exp_q.pop_front();
    if (!m_running) begin
      if (run) begin
        m_running = 1'b1;
        m_busy = 1'b1;
        m_start = c + CC;
      end
    end else begin
      if (c == m_start) begin
        m_len = (integ_len == 0) ? 1 : int'(integ_len);
        m_cap = c + m_len + 1;
        m_en = 1'b1;
        m_rst = 1'b0;
      end
      if (c == m_cap - 1) m_en = 1'b0;
      if (c == m_cap) begin
        m_rst = 1'b1;
        m_fc = m_fc + 16'd1;
        if (exp_q.size() == 0) begin
          for (int i = 0; i < NC; i++)
            exp_q.push_back({(i == NC - 1), IDX_W'(i), R'(m_len * (i + 1)), R'(m_len)});
        end else begin
          set_ovr = 1'b1;
        end
        m_start = c + CC;
      end
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  task automatic model_compare();
    chk("rnd_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("rnd_data", 32'(out_data), 32'(exp_q[0][SW-1:0]));
      chk("rnd_index", 32'(out_index), 32'(exp_q[0][SW+IDX_W-1:SW]));
      chk("rnd_last", 32'(out_last), 32'(exp_q[0][BW-1]));
    end
    chk("rnd_enable", 32'(corr_enable), 32'(m_en));
    chk("rnd_corr_reset", 32'(corr_reset), 32'(m_rst));
    chk("rnd_frame_count", 32'(frame_count), 32'(m_fc));
    chk("rnd_overrun", 32'(overrun), 32'(m_ovr));
    chk("rnd_busy", 32'(busy), 32'(m_busy));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int base;
    int pct;
    int pcts[4];
    logic saw;
    logic [BW-1:0] beat0;

    pcts = '{90, 30, 100, 15};
    vecs[0] = '{5, 5, 5, 8};
    vecs[1] = '{0, 1, 1, 4};
    vecs[2] = '{3, 3, 3, 6};
    vecs[3] = '{1, 1, 1, 4};

    rst_n = 1'b0;
    run = 1'b0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;
    integ_len = '0;

    // reset state
    @(negedge clk);
    chk("rst_enable", 32'(corr_enable), 32'd0);
    chk("rst_corr_reset", 32'(corr_reset), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // table-driven frame vectors (test plan items 1 and 2)
    foreach (vecs[v]) begin
      do_reset();
      integ_len = IW'(vecs[v].len);
      out_ready = 1'b1;
      base = rise_q.size();
      run = 1'b1;
      wait_en("vec_en_rise");
      n = 0;
      while (corr_enable && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("vec_en_clocks", 32'(n), 32'(vecs[v].exp_en));
      wait_valid("vec_first_valid");
      for (int k = 0; k < NC; k++) begin
        check_beat("vec_beat", k, vecs[v].exp_val, vecs[v].exp_val);
        @(negedge clk);
      end
      n = 0;
      while (rise_q.size() < base + 2 && n < 64) begin
        @(negedge clk);
        n++;
      end
      chk("vec_second_frame", 32'(rise_q.size() >= base + 2), 32'd1);
      if (rise_q.size() >= base + 2)
        chk("vec_period", 32'(rise_q[base+1] - rise_q[base]), 32'(vecs[v].exp_period));
    end

    // overrun with a stalled consumer
    do_reset();
    integ_len = IW'(5);
    run = 1'b1;
    wait_valid("ovr_first_valid");
    chk("ovr_fc_first", 32'(frame_count), 32'd1);
    beat0 = {out_last, out_index, out_data};
    for (int i = 0; i < 20; i++) begin
      chk("ovr_hold_beat", 32'({out_last, out_index, out_data}), 32'(beat0));
      chk("ovr_hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    chk("ovr_flag_set", 32'(overrun), 32'd1);
    chk("ovr_fc_counts", 32'(frame_count), 32'd3);
    out_ready = 1'b1;
    for (int k = 0; k < NC; k++) begin
      check_beat("ovr_beat", k, 5, 5);
      @(negedge clk);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_flag_cleared", 32'(overrun), 32'd0);

    // run dropped mid-integration
    do_reset();
    integ_len = IW'(5);
    out_ready = 1'b1;
    run = 1'b1;
    wait_en("abort_en_rise");
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("abort_corr_reset", 32'(corr_reset), 32'd1);
    chk("abort_enable", 32'(corr_enable), 32'd0);
    chk("abort_busy_a", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_busy_b", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || corr_enable) saw = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_beat", 32'(saw), 32'd0);
    chk("abort_fc", 32'(frame_count), 32'd0);

    // reset mid-readout
    do_reset();
    integ_len = IW'(5);
    out_ready = 1'b1;
    run = 1'b1;
    wait_valid("mrst_first_valid");
    chk("mrst_idx0", 32'(out_index), 32'd0);
    @(negedge clk);
    chk("mrst_idx1", 32'(out_index), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_corr_reset", 32'(corr_reset), 32'd1);
    chk("mrst_enable", 32'(corr_enable), 32'd0);
    chk("mrst_index", 32'(out_index), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_fc", 32'(frame_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("mrst_restart_valid");
    chk("mrst_restart_fc", 32'(frame_count), 32'd1);
    check_beat("mrst_restart_beat", 0, 5, 5);

    // last beat accepted on the capture edge
    do_reset();
    integ_len = IW'(3);
    run = 1'b1;
    wait_valid("coin_first_valid");
    chk("coin_fc_first", 32'(frame_count), 32'd1);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < NC; k++) begin
      check_beat("coin_beat", k, 3, 3);
      @(negedge clk);
    end
    check_beat("coin_new_frame", 0, 3, 3);
    chk("coin_overrun", 32'(overrun), 32'd0);
    chk("coin_fc", 32'(frame_count), 32'd2);

    // randomized run against the model
    do_reset();
    stub_mode = 1;
    model_init();
    run = 1'b1;
    pct = pcts[0];
    for (int c = 0; c < RND_CYCLES; c++) begin
      if (c % 200 == 0) pct = pcts[c / 200];
      out_ready = ($urandom_range(0, 99) < pct);
      integ_len = IW'($urandom_range(0, 6));
      overrun_clr = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      model_step(c);
      @(negedge clk);
      model_compare();
    end
    run = 1'b0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
